polyvec_load_ctrl: RTL

- Producer side of the operand-load handshake for the polyvec basemul-accumulate datapath.
- After a readin_ok pulse from the accumulate controller, accepts a valid/ready stream of packed coefficient words and writes them into RAM A and RAM B, polynomial by polynomial.
- When all KYBER_K polynomials are written, pulses full_in back to the controller.
- Sits between the external operand source and the RAM A/B write ports.

---
 rtl/polyvec_load_ctrl_pkg.sv | 21 ++
 rtl/polyvec_load_addr_gen.sv | 53 +++++
 rtl/polyvec_load_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/polyvec_load_ctrl_pkg.sv
// Shared constants, state encoding and sizing helper for the polyvec operand-load path.
package polyvec_load_ctrl_pkg;

    localparam int COEF_W      = 12;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_KYBER_K = 3;
    localparam int DEF_DATA_W  = 2 * COEF_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // RAM words per polynomial for a given controller counter width.
    function automatic int words_of(input int depth);
        return 1 << (depth - 1);
    endfunction

endpackage

// File: rtl/polyvec_load_addr_gen.sv
// Word/polynomial counter with wrap and last-word detection; composes the RAM address
// as poly*WORDS + word. Also usable for the RAM C readout path.
module polyvec_load_addr_gen
    import polyvec_load_ctrl_pkg::*;
#(
    parameter  int WORDS   = words_of(DEF_DEPTH),
    parameter  int KYBER_K = DEF_KYBER_K,
    parameter  int ADDR_W  = DEF_DEPTH + 1,
    localparam int WORD_W  = $clog2(WORDS),
    localparam int POLY_W  = ADDR_W - WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_adv,
    output logic [POLY_W-1:0] o_poly,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [WORD_W-1:0] r_word;
    logic [POLY_W-1:0] r_poly;
    logic              w_last_word;
    logic              w_last_poly;

    assign w_last_word = (r_word == WORD_W'(WORDS - 1));
    assign w_last_poly = (r_poly == POLY_W'(KYBER_K - 1));

    // The polynomial index saturates at the last polynomial so k never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word <= '0;
            r_poly <= '0;
        end else if (i_clr) begin
            r_word <= '0;
            r_poly <= '0;
        end else if (i_adv) begin
            if (w_last_word) begin
                r_word <= '0;
                if (!w_last_poly) begin
                    r_poly <= r_poly + POLY_W'(1);
                end
            end else begin
                r_word <= r_word + WORD_W'(1);
            end
        end
    end

    assign o_poly = r_poly;
    assign o_addr = {r_poly, r_word};
    assign o_last = w_last_word & w_last_poly;

endmodule

// File: rtl/polyvec_load_ctrl.sv
// Producer side of the polyvec operand-load handshake: after readin_ok, streams
// KYBER_K polynomials of word pairs into RAM A/B and pulses full_in when complete.
module polyvec_load_ctrl
    import polyvec_load_ctrl_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int KYBER_K = DEF_KYBER_K,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEPTH + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set,
    input  logic              readin_ok,
    input  logic              ram_we_ok,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data_a,
    input  logic [DATA_W-1:0] in_data_b,
    output logic              ram_a_we,
    output logic              ram_b_we,
    output logic [ADDR_W-1:0] ram_a_addr,
    output logic [ADDR_W-1:0] ram_b_addr,
    output logic [DATA_W-1:0] ram_a_din,
    output logic [DATA_W-1:0] ram_b_din,
    output logic              full_in,
    output logic              busy,
    output logic [2:0]        k,
    output logic              err_restart,
    output state_t            o_dbg_state
);

    localparam int WORDS  = words_of(DEPTH);
    localparam int POLY_W = ADDR_W - $clog2(WORDS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_in_ready;
    logic              w_xfer;
    logic              w_start;
    logic              w_restart;
    logic              w_busy;
    logic [POLY_W-1:0] w_poly;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din_a;
    logic [DATA_W-1:0] r_din_b;
    logic              r_full;
    logic              r_err;
    logic              r_err_pend;

    polyvec_load_addr_gen #(
        .WORDS   (WORDS),
        .KYBER_K (KYBER_K),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_start),
        .i_adv  (w_xfer),
        .o_poly (w_poly),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start)              w_state_nxt = ST_ARM;
            ST_ARM:  if (set && ram_we_ok)     w_state_nxt = ST_LOAD;
            ST_LOAD: if (w_xfer && w_last)     w_state_nxt = ST_DONE;
            ST_DONE: if (set)                  w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake: a word pair moves on a rising edge where in_valid and in_ready are
    // both high; in_ready never depends on in_valid, and the source may hold in_valid.
    always_comb begin
        w_in_ready = set & ram_we_ok & (r_state == ST_LOAD);
        w_xfer     = in_valid & w_in_ready;
        w_start    = set & readin_ok & (r_state == ST_IDLE);
        w_restart  = readin_ok & (r_state != ST_IDLE);
        w_busy     = (r_state != ST_IDLE);
    end

    // With set low, a restart error is remembered and emitted once set returns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_din_a    <= '0;
            r_din_b    <= '0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
            r_err_pend <= 1'b0;
        end else if (set) begin
            r_we       <= w_xfer;
            r_full     <= (r_state == ST_DONE);
            r_err      <= w_restart | r_err_pend;
            r_err_pend <= 1'b0;
            if (w_xfer) begin
                r_addr  <= w_addr;
                r_din_a <= in_data_a;
                r_din_b <= in_data_b;
            end
        end else begin
            r_we   <= 1'b0;
            r_full <= 1'b0;
            r_err  <= 1'b0;
            if (w_restart) begin
                r_err_pend <= 1'b1;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign busy        = w_busy;
    assign ram_a_we    = r_we;
    assign ram_b_we    = r_we;
    assign ram_a_addr  = r_addr;
    assign ram_b_addr  = r_addr;
    assign ram_a_din   = r_din_a;
    assign ram_b_din   = r_din_b;
    assign full_in     = r_full;
    assign err_restart = r_err;
    assign k           = 3'(w_poly) + 3'd1;
    assign o_dbg_state = r_state;

endmodule
